// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor built from one full-adder cell
// and a carry flop. WIDTH-bit operands are consumed LSB-first, one bit per
// clock, behind a start/busy/done handshake.
//
// Optional feature: define SERIAL_ADDER_OVF_EN to add the ovf output, the
// signed-overflow flag, valid with done.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CNT_W-1:0] cnt;
  logic             c;
  logic             bit_s;
  logic             bit_c;

  // Full-adder cell on the current LSBs and the running carry.
  always_comb begin
    bit_s = a_reg[0] ^ b_reg[0] ^ c;
    bit_c = (a_reg[0] & b_reg[0]) | (a_reg[0] & c) | (b_reg[0] & c);
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic c_msb;

  // Carry into the MSB cell, latched on the last RUN edge and held with sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_msb <= 1'b0;
    end else if (state == RUN && cnt == LAST) begin
      c_msb <= c;
    end
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovf = c_msb ^ carry;
`endif

  // Control FSM plus the serial datapath; all outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the async reset clears every flop, including the shift
    // registers, so sum reads 0 and no partial result leaks after an abort.
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every right-hand side sees
      // the pre-edge value, as the flops in hardware do.
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            c     <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum   <= {bit_s, sum[WIDTH-1:1]};
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          c     <= bit_c;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            carry <= bit_c;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: a WIDTH=8 instance for the directed, handshake,
// reset and random cases, and a WIDTH=3 instance for the exhaustive sweep.
// Expected results come from an arithmetic reference model and are queued at
// acceptance; monitors pop and compare on each done pulse.
module tb_serial_adder;

  typedef struct {
    logic [63:0] sum;
    logic        carry;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, carry8;
  logic [7:0] sum8;

  logic       start3 = 1'b0, sub3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       busy3, done3, carry3;
  logic [2:0] sum3;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf8, ovf3;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t q8[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .sub(sub3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .sum(sum3), .carry(carry3)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf3)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {carry,sum} = a + (sub ? 2^w - b : b) in (w+1)-bit arithmetic;
  // ovf = the true signed result does not fit in w bits.
  function automatic exp_t model(input int w, input logic [63:0] av,
                                 input logic [63:0] bv, input logic sub_v);
    exp_t        r;
    logic [64:0] mask;
    logic [64:0] tot;
    longint      sa, sb, res;
    mask  = (65'd1 << w) - 65'd1;
    tot   = {1'b0, av} + (sub_v ? (((~{1'b0, bv}) & mask) + 65'd1) : {1'b0, bv});
    r.sum   = 64'(tot & mask);
    r.carry = tot[w];
    sa = longint'(av) - (av[w-1] ? (longint'(1) << w) : 0);
    sb = longint'(bv) - (bv[w-1] ? (longint'(1) << w) : 0);
    res = sub_v ? sa - sb : sa + sb;
    r.ovf = (res > (longint'(1) << (w - 1)) - 1) || (res < -(longint'(1) << (w - 1)));
    return r;
  endfunction

  // Monitor for the 8-bit instance: every done pulse must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        check("unexpected_done8", 64'(done8), 64'd0);
      end else begin
        e = q8.pop_front();
        check("sum8", 64'(sum8), e.sum);
        check("carry8", 64'(carry8), 64'(e.carry));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf8", 64'(ovf8), 64'(e.ovf));
`endif
      end
    end
  end

  // Monitor for the 3-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done3) begin
      if (q3.size() == 0) begin
        check("unexpected_done3", 64'(done3), 64'd0);
      end else begin
        e = q3.pop_front();
        check("sum3", 64'(sum3), e.sum);
        check("carry3", 64'(carry3), 64'(e.carry));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf3", 64'(ovf3), 64'(e.ovf));
`endif
      end
    end
  end

  task automatic wait_idle8();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy8) break;
    end
    if (busy8) check("idle8_timeout", 64'(busy8), 64'd0);
  endtask

  task automatic wait_idle3();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy3) break;
    end
    if (busy3) check("idle3_timeout", 64'(busy3), 64'd0);
  endtask

  // Issue one operation; operands are scrambled right after the accepting edge.
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv,
                        input logic sv, input bit push);
    wait_idle8();
    a8 = av; b8 = bv; sub8 = sv; start8 = 1'b1;
    @(posedge clk);
    if (push) q8.push_back(model(8, 64'(av), 64'(bv), sv));
    #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
  endtask

  task automatic issue3(input logic [2:0] av, input logic [2:0] bv, input logic sv);
    wait_idle3();
    a3 = av; b3 = bv; sub3 = sv; start3 = 1'b1;
    @(posedge clk);
    q3.push_back(model(3, 64'(av), 64'(bv), sv));
    #1;
    start3 = 1'b0; a3 = 3'($urandom); b3 = 3'($urandom); sub3 = 1'($urandom);
  endtask

  initial begin
    // Reset and reset-state outputs.
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_sum", 64'(sum8), 64'd0);
    check("rst_carry", 64'(carry8), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 64'(ovf8), 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Handshake timing: accept at edge 0, done seen only after edge WIDTH,
    // busy seen after edges 0..WIDTH.
    a8 = 8'h5A; b8 = 8'h3C; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    q8.push_back(model(8, 64'h5A, 64'h3C, 1'b0));
    #1 start8 = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("t1_busy_e%0d", k), 64'(busy8), 64'(k <= 8));
      check($sformatf("t1_done_e%0d", k), 64'(done8), 64'(k == 8));
    end

    // Directed arithmetic and overflow corner cases.
    issue8(8'hFF, 8'h01, 1'b0, 1'b1);
    issue8(8'h10, 8'h20, 1'b1, 1'b1);
    issue8(8'h7F, 8'h01, 1'b0, 1'b1);
    issue8(8'h80, 8'h01, 1'b1, 1'b1);
    issue8(8'h05, 8'h03, 1'b0, 1'b1);
    issue8(8'h00, 8'h00, 1'b1, 1'b1);
    issue8(8'h80, 8'h80, 1'b0, 1'b1);

    // start held high with operands changing every cycle: acceptances occur
    // every WIDTH+2 edges and use only the values present at those edges.
    wait_idle8();
    for (int e = 0; e < 3 * 10; e++) begin
      logic [7:0] ra, rb;
      logic       rs;
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      a8 = ra; b8 = rb; sub8 = rs; start8 = 1'b1;
      @(posedge clk);
      if (e % 10 == 0) q8.push_back(model(8, 64'(ra), 64'(rb), rs));
      @(negedge clk);
      check($sformatf("t3_busy_e%0d", e), 64'(busy8), 64'(e % 10 != 9));
    end
    start8 = 1'b0;

    // Reset at RUN edge 4 aborts: outputs clear at once and no done follows.
    issue8(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t4_busy", 64'(busy8), 64'd0);
    check("t4_done", 64'(done8), 64'd0);
    check("t4_sum", 64'(sum8), 64'd0);
    check("t4_carry", 64'(carry8), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t4_no_done", 64'(done8), 64'd0);
    end
    issue8(8'hC8, 8'h64, 1'b1, 1'b1);

    // Randomised operations.
    for (int i = 0; i < 40; i++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end

    // Exhaustive sweep at WIDTH=3.
    for (int av = 0; av < 8; av++) begin
      for (int bv = 0; bv < 8; bv++) begin
        for (int sv = 0; sv < 2; sv++) begin
          issue3(3'(av), 3'(bv), 1'(sv));
        end
      end
    end

    // Drain: every queued expectation must have been consumed by a done.
    wait_idle8();
    wait_idle3();
    repeat (3) @(negedge clk);
    check("sb8_drain", 64'(q8.size()), 64'd0);
    check("sb3_drain", 64'(q3.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
